wb_port_arbiter: RTL and testbench

- Owns the single register-file write port.
- Shares it between the in-order pipeline writeback (output of the WB mux) and a long-latency unit (multiply/divide) that returns results out of band.
- Long-latency results are queued in a small FIFO and drained in cycles the pipeline does not write. An anti-starvation counter forces a one-cycle pipeline stall when the queue is blocked too long.
- Also provides a pending-destination lookup so the hazard unit can hold issue of WAW/RAW-dependent instructions.

---
 rtl/wb_port_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Owns the single register-file write port. Two sources share it:
//   * the in-order pipeline writeback (always preferred, zero latency), and
//   * a long-latency unit (mul/div) whose results arrive out of band.
// Long-latency results wait in a small FIFO. The FIFO head drains in any
// cycle the pipeline does not write. If the head is blocked for MAX_WAIT
// consecutive cycles, a one-cycle pipeline stall is requested. In the stall
// cycle the head takes the port and the pipeline replays its write.
// A pending-destination lookup (q_rd -> q_pending) lets the hazard unit hold
// issue of instructions that depend on a queued result.
//
// Optional feature: define WB_BYPASS_EN to let a long-latency result write the
// register file in its arrival cycle. This happens only when the FIFO is
// empty, the pipeline is not writing and no stall is in progress.
//
// Parameters:
//   N        data width
//   RD_W     destination register index width
//   DEPTH    FIFO entries (power of two, >= 2)
//   MAX_WAIT blocked cycles tolerated before a forced stall (>= 1)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pipe_wr_en/rd/data    pipeline writeback request
//   mc_valid/rd/data      long-latency result, accepted when mc_ready is high
//   mc_ready              FIFO has room (registered)
//   rf_wr_en/addr/data    register-file write port
//   pipe_stall            pipeline must hold and replay its WB next cycle
//   q_rd, q_pending       hazard lookup against queued destinations
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int N        = 32,
  parameter int RD_W     = 6,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_wr_en,
  input  logic [RD_W-1:0] pipe_rd,
  input  logic [N-1:0]    pipe_data,
  input  logic            mc_valid,
  input  logic [RD_W-1:0] mc_rd,
  input  logic [N-1:0]    mc_data,
  output logic            mc_ready,
  output logic            rf_wr_en,
  output logic [RD_W-1:0] rf_wr_addr,
  output logic [N-1:0]    rf_wr_data,
  output logic            pipe_stall,
  input  logic [RD_W-1:0] q_rd,
  output logic            q_pending
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  localparam logic [PTR_W:0]    DEPTH_C   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [RD_W-1:0]   RD_ZERO   = '0;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [RD_W-1:0]   rd_mem   [DEPTH];
  logic [N-1:0]      data_mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W:0]    count_reg, count_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic              stall_reg, stall_next;
  logic              mc_ready_reg, mc_ready_next;

  // ---------------------------------------------------------------------------
  // Request decode and grant
  // ---------------------------------------------------------------------------
  logic            pipe_write;
  logic            fifo_empty;
  logic            head_grant;
  logic            pipe_grant;
  logic            bypass_grant;
  logic            blocked;
  logic            accept;
  logic            push;
  logic            pop;
  logic [RD_W-1:0] head_rd;
  logic [N-1:0]    head_data;

  // Writes to register 0 are architecturally dead and never use the port.
  assign pipe_write = pipe_wr_en && (pipe_rd != RD_ZERO);
  assign fifo_empty = (count_reg == '0);
  assign head_rd    = rd_mem[rd_ptr_reg];
  assign head_data  = data_mem[rd_ptr_reg];

  // A stall cycle always has a non-empty FIFO, because nothing can pop
  // between the stall decision and the stall cycle. The empty check only
  // keeps the head grant safe on its own.
  assign head_grant = !fifo_empty && (stall_reg || !pipe_write);
  assign pipe_grant = pipe_write && !stall_reg;

`ifdef WB_BYPASS_EN
  assign bypass_grant = fifo_empty && !pipe_write && !stall_reg &&
                        mc_valid && (mc_rd != RD_ZERO);
`else
  assign bypass_grant = 1'b0;
`endif

  // The head is denied only by a competing pipeline write. A stall cycle
  // pops the head, so it can never count as blocked. This is also why
  // pipe_stall cannot assert on back-to-back cycles.
  assign blocked = !fifo_empty && pipe_write && !stall_reg;

  // mc_ready comes from the registered count only. A full FIFO refuses a
  // push even in a cycle where it also pops.
  assign accept = mc_valid && mc_ready_reg;
  assign push   = accept && (mc_rd != RD_ZERO) && !bypass_grant;
  assign pop    = head_grant;

  always_comb begin
    rf_wr_en   = 1'b0;
    rf_wr_addr = pipe_rd;
    rf_wr_data = pipe_data;
    if (head_grant) begin
      rf_wr_en   = 1'b1;
      rf_wr_addr = head_rd;
      rf_wr_data = head_data;
    end else if (pipe_grant) begin
      rf_wr_en   = 1'b1;
    end else if (bypass_grant) begin
      rf_wr_en   = 1'b1;
      rf_wr_addr = mc_rd;
      rf_wr_data = mc_data;
    end
    // The write port stays quiet for the whole time reset is asserted,
    // including the partial cycle before the next clock edge.
    if (!rst_n) begin
      rf_wr_en = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (push && !pop) begin
      count_next = count_reg + CNT_ONE;
    end else if (pop && !push) begin
      count_next = count_reg - CNT_ONE;
    end
    mc_ready_next = (count_next < DEPTH_C);
  end

  // ---------------------------------------------------------------------------
  // Anti-starvation counter
  // ---------------------------------------------------------------------------
  always_comb begin
    wait_next  = wait_reg;
    stall_next = 1'b0;
    if (pop || fifo_empty) begin
      wait_next = '0;
    end else if (blocked) begin
      if (wait_reg == WAIT_LAST) begin
        wait_next  = '0;
        stall_next = 1'b1;
      end else begin
        wait_next = wait_reg + WAIT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      wait_reg     <= '0;
      stall_reg    <= 1'b0;
      mc_ready_reg <= 1'b1;
    end else begin
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      wait_reg     <= wait_next;
      stall_reg    <= stall_next;
      mc_ready_reg <= mc_ready_next;
    end
  end

  // Entry storage needs no reset. Validity is tracked by the pointers and
  // the count.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_reg]   <= mc_rd;
      data_mem[wr_ptr_reg] <= mc_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-destination lookup
  // ---------------------------------------------------------------------------
  // A slot is live when its distance from the read pointer is below the
  // count. The head still counts in the cycle it is popped, because the
  // register file is only updated at the end of that cycle.
  logic [DEPTH-1:0] slot_hit;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [PTR_W-1:0] slot_offset;
    logic             slot_live;
    assign slot_offset  = PTR_W'(gi) - rd_ptr_reg;
    assign slot_live    = ({1'b0, slot_offset} < count_reg);
    assign slot_hit[gi] = slot_live && (rd_mem[gi] == q_rd);
  end

  assign q_pending  = (q_rd != RD_ZERO) && (|slot_hit);

  assign mc_ready   = mc_ready_reg;
  assign pipe_stall = stall_reg;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for wb_port_arbiter.
// A queue-based reference model follows the arbitration rules. One compare
// process checks every DUT output against it on each falling edge. Directed
// stimulus walks the scenarios, and hand-computed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

  localparam int N        = 32;
  localparam int RD_W     = 6;
  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            pipe_wr_en;
  logic [RD_W-1:0] pipe_rd;
  logic [N-1:0]    pipe_data;
  logic            mc_valid;
  logic [RD_W-1:0] mc_rd;
  logic [N-1:0]    mc_data;
  logic            mc_ready;
  logic            rf_wr_en;
  logic [RD_W-1:0] rf_wr_addr;
  logic [N-1:0]    rf_wr_data;
  logic            pipe_stall;
  logic [RD_W-1:0] q_rd;
  logic            q_pending;

  wb_port_arbiter #(
    .N(N), .RD_W(RD_W), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wr_en(pipe_wr_en), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data), .mc_ready(mc_ready),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .pipe_stall(pipe_stall), .q_rd(q_rd), .q_pending(q_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: queue of pending results, blocked-cycle tally, stall flag
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [RD_W-1:0] rd;
    logic [N-1:0]    data;
  } ent_t;

  ent_t m_q[$];
  int   m_wait  = 0;
  bit   m_stall = 1'b0;

  bit   u_pw, u_byp, u_pop, u_push, u_ready, u_newstall;
  ent_t u_ent;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_wait  = 0;
        m_stall = 1'b0;
      end else begin
        u_pw       = pipe_wr_en && (pipe_rd != 0);
        u_ready    = (m_q.size() < DEPTH);
        u_byp      = BYP && (m_q.size() == 0) && !u_pw && !m_stall && mc_valid && (mc_rd != 0);
        u_pop      = (m_q.size() > 0) && (m_stall || !u_pw);
        u_newstall = 1'b0;
        if (u_pop || m_q.size() == 0) begin
          m_wait = 0;
        end else if (u_pw && !m_stall) begin
          // Head was refused in favour of the pipeline this cycle.
          if (m_wait == MAX_WAIT - 1) begin
            u_newstall = 1'b1;
            m_wait     = 0;
          end else begin
            m_wait = m_wait + 1;
          end
        end
        u_push = mc_valid && u_ready && (mc_rd != 0) && !u_byp;
        if (u_pop) void'(m_q.pop_front());
        if (u_push) begin
          u_ent.rd   = mc_rd;
          u_ent.data = mc_data;
          m_q.push_back(u_ent);
        end
        m_stall = u_newstall;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle comparison against the model
  // ---------------------------------------------------------------------------
  bit              e_pw, e_en, e_pend;
  logic [RD_W-1:0] e_addr;
  logic [N-1:0]    e_data;

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        e_pw   = pipe_wr_en && (pipe_rd != 0);
        e_en   = 1'b0;
        e_addr = '0;
        e_data = '0;
        if (!rst_n) begin
          e_en = 1'b0;
        end else if (m_stall && m_q.size() > 0) begin
          e_en = 1'b1; e_addr = m_q[0].rd; e_data = m_q[0].data;
        end else if (e_pw) begin
          e_en = 1'b1; e_addr = pipe_rd; e_data = pipe_data;
        end else if (m_q.size() > 0) begin
          e_en = 1'b1; e_addr = m_q[0].rd; e_data = m_q[0].data;
        end else if (BYP && mc_valid && mc_rd != 0) begin
          e_en = 1'b1; e_addr = mc_rd; e_data = mc_data;
        end
        e_pend = 1'b0;
        if (q_rd != 0) begin
          foreach (m_q[i]) if (m_q[i].rd == q_rd) e_pend = 1'b1;
        end
        check("model_rf_wr_en", 32'(rf_wr_en), 32'(e_en));
        if (e_en) begin
          check("model_rf_wr_addr", 32'(rf_wr_addr), 32'(e_addr));
          check("model_rf_wr_data", rf_wr_data, e_data);
        end
        check("model_mc_ready", 32'(mc_ready), 32'(m_q.size() < DEPTH));
        check("model_pipe_stall", 32'(pipe_stall), 32'(m_stall));
        check("model_q_pending", 32'(q_pending), 32'(e_pend));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input logic pwe, input logic [RD_W-1:0] prd, input logic [N-1:0] pd,
                       input logic mv, input logic [RD_W-1:0] mrd, input logic [N-1:0] md);
    pipe_wr_en = pwe; pipe_rd = prd; pipe_data = pd;
    mc_valid   = mv;  mc_rd   = mrd; mc_data   = md;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    q_rd  = '0;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    cmp_en = 1'b1;
    #1;

    // Reset state
    neg;
    check("rst_rf_wr_en", 32'(rf_wr_en), 0);
    check("rst_mc_ready", 32'(mc_ready), 1);
    check("rst_pipe_stall", 32'(pipe_stall), 0);
    nxt;
    rst_n = 1'b1;
    q_rd  = 6'd5;
    for (int k = 0; k < 2; k++) begin
      neg;
      check("idle_rf_wr_en", 32'(rf_wr_en), 0);
      check("idle_mc_ready", 32'(mc_ready), 1);
      check("idle_q_pending", 32'(q_pending), 0);
      nxt;
    end

    // Pipeline wins, the queued result follows next cycle
    drive(1, 6'd5, 32'hDEADBEEF, 1, 6'd7, 32'h11);
    q_rd = 6'd7;
    neg;
    check("pipe_first_en", 32'(rf_wr_en), 1);
    check("pipe_first_addr", 32'(rf_wr_addr), 5);
    check("pipe_first_data", rf_wr_data, 32'hDEADBEEF);
    check("pend_before_push", 32'(q_pending), 0);
    nxt;
    drive(0, 0, 0, 0, 0, 0);
    neg;
    check("mc_next_addr", 32'(rf_wr_addr), 7);
    check("mc_next_data", rf_wr_data, 32'h11);
    check("pend_while_pop", 32'(q_pending), 1);
    nxt;
    neg;
    check("drained_en", 32'(rf_wr_en), 0);
    nxt;

    // Fill the FIFO behind a continuous pipeline write
    for (int k = 0; k < 4; k++) begin
      drive(1, 6'd10, 32'hA0 + k, 1, 6'(k + 1), 32'h100 + k);
      neg;
      check("fill_ready", 32'(mc_ready), 1);
      check("fill_pipe_addr", 32'(rf_wr_addr), 10);
      nxt;
    end
    drive(1, 6'd10, 32'hA4, 1, 6'd5, 32'h105);
    q_rd = 6'd3;
    neg;
    check("full_ready", 32'(mc_ready), 0);
    check("full_pend_r3", 32'(q_pending), 1);
    nxt;
    drive(1, 6'd10, 32'hA5, 1, 6'd5, 32'h105);
    q_rd = 6'd9;
    neg;
    check("full_pend_r9", 32'(q_pending), 0);
    nxt;
    drive(0, 0, 0, 1, 6'd5, 32'h105);
    neg;
    check("drain0_ready", 32'(mc_ready), 0);
    check("drain0_addr", 32'(rf_wr_addr), 1);
    check("drain0_data", rf_wr_data, 32'h100);
    nxt;
    neg;
    check("drain1_ready", 32'(mc_ready), 1);
    check("drain1_addr", 32'(rf_wr_addr), 2);
    nxt;
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      neg;
      check("drain_order", 32'(rf_wr_addr), 32'(k + 3));
      nxt;
    end
    neg;
    check("drain_done_en", 32'(rf_wr_en), 0);
    nxt;

    // Pipe-free arrival into an empty FIFO
    drive(0, 0, 0, 1, 6'd8, 32'h22);
    neg;
`ifdef WB_BYPASS_EN
    check("byp_same_en", 32'(rf_wr_en), 1);
    check("byp_same_addr", 32'(rf_wr_addr), 8);
`else
    check("nobyp_same_en", 32'(rf_wr_en), 0);
`endif
    nxt;
    drive(0, 0, 0, 0, 0, 0);
    neg;
`ifdef WB_BYPASS_EN
    check("byp_next_en", 32'(rf_wr_en), 0);
`else
    check("nobyp_next_addr", 32'(rf_wr_addr), 8);
    check("nobyp_next_data", rf_wr_data, 32'h22);
`endif
    nxt;
    neg;
    nxt;

    // Starvation: one entry, pipeline writing every cycle
    drive(1, 6'd13, 32'h1300, 1, 6'd12, 32'hABC);
    neg;
    check("starve_enq_addr", 32'(rf_wr_addr), 13);
    nxt;
    drive(1, 6'd13, 32'h1300, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      neg;
      check("starve_no_stall", 32'(pipe_stall), 0);
      check("starve_pipe_addr", 32'(rf_wr_addr), 13);
      nxt;
    end
    neg;
    check("stall_cycle", 32'(pipe_stall), 1);
    check("stall_head_addr", 32'(rf_wr_addr), 12);
    check("stall_head_data", rf_wr_data, 32'hABC);
    nxt;
    neg;
    check("replay_stall", 32'(pipe_stall), 0);
    check("replay_addr", 32'(rf_wr_addr), 13);
    check("replay_data", rf_wr_data, 32'h1300);
    nxt;
    drive(0, 0, 0, 0, 0, 0);
    neg;
    nxt;

    // Register-0 pipeline write leaves the port to the FIFO head
    drive(1, 6'd14, 32'h1400, 1, 6'd2, 32'h202);
    neg;
    nxt;
    drive(1, 6'd0, 32'h99, 0, 0, 0);
    neg;
    check("r0_head_en", 32'(rf_wr_en), 1);
    check("r0_head_addr", 32'(rf_wr_addr), 2);
    check("r0_head_data", rf_wr_data, 32'h202);
    nxt;
    drive(0, 0, 0, 0, 0, 0);
    neg;
    nxt;

    // Three queued, a discarded rd=0 result, then reset during a stall
    q_rd = 6'd21;
    for (int k = 0; k <= 8; k++) begin
      if (k < 3)       drive(1, 6'd30, 32'h3000 + k, 1, 6'(20 + k), 32'h2000 + k);
      else if (k == 3) drive(1, 6'd30, 32'h3000 + k, 1, 6'd0, 32'hBAD);
      else             drive(1, 6'd30, 32'h3000 + k, 0, 0, 0);
      neg;
      if (k == 4) begin
        check("rd0_not_pushed", 32'(mc_ready), 1);
        check("three_pend_r21", 32'(q_pending), 1);
      end
      nxt;
    end
    drive(1, 6'd30, 32'h3009, 0, 0, 0);
    neg;
    check("pre_rst_stall", 32'(pipe_stall), 1);
    check("pre_rst_addr", 32'(rf_wr_addr), 20);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_en", 32'(rf_wr_en), 0);
    check("async_rst_stall", 32'(pipe_stall), 0);
    nxt;
    drive(0, 0, 0, 0, 0, 0);
    neg;
    nxt;
    rst_n = 1'b1;
    q_rd  = 6'd20;
    for (int k = 0; k < 3; k++) begin
      neg;
      check("post_rst_ready", 32'(mc_ready), 1);
      check("post_rst_pend", 32'(q_pending), 0);
      check("post_rst_no_write", 32'(rf_wr_en), 0);
      nxt;
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
